// File: rtl/dtpu_csr_slave_pkg.sv
// Shared definitions for the DTPU CSR slave:
// AXI word indices, CTRL bit positions and CU word indices.
package dtpu_csr_slave_pkg;

    localparam logic [3:0] W_CTRL = 4'h0;
    localparam logic [3:0] W_PREC = 4'h4;
    localparam logic [3:0] W_WM   = 4'h5;
    localparam logic [3:0] W_STAT = 4'h6;
    localparam logic [3:0] W_DCNT = 4'h7;

    localparam int B_START = 0;
    localparam int B_DONE  = 1;
    localparam int B_IDLE  = 2;
    localparam int B_READY = 3;
    localparam int B_GLB   = 4;
    localparam int B_CONT  = 5;

    localparam int unsigned A_ARITHMETIC_PRECISION = 1;
    localparam int unsigned A_FP_MODE              = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        CH_IDLE,
        CH_RESP
    } chan_e;

    function automatic logic is_mapped(input logic [3:0] w);
        return (w == W_CTRL) || (w == W_PREC) ||
               (w == W_WM) || (w == W_STAT) ||
               (w == W_DCNT);
    endfunction

endpackage

// File: rtl/dtpu_csr_slave_axil_slave_if.sv
// AXI4-Lite handshake FSMs: AW/W capture, B response,
// AR accept and registered R response.
module dtpu_csr_slave_axil_slave_if
    import dtpu_csr_slave_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   s_axi_awaddr,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [DW-1:0]   s_axi_wdata,
    input  logic [DW/8-1:0] s_axi_wstrb,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [AW-1:0]   s_axi_araddr,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [DW-1:0]   s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [DW/8-1:0] wr_strb,
    input  logic            wr_err,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    input  logic            rd_err,
    output logic            rd_ack,
    output logic [AW-1:0]   rd_ack_addr
);

    logic            up_q;
    logic            aw_hold;
    logic            w_hold;
    logic [AW-1:0]   aw_q;
    logic [AW-1:0]   ar_q;
    logic [DW-1:0]   w_q;
    logic [DW/8-1:0] ws_q;
    chan_e           b_st;
    chan_e           r_st;
    logic            b_stall;
    logic            r_stall;
    logic            aw_acc;
    logic            w_acc;

    assign b_stall = (b_st == CH_RESP) && !s_axi_bready;
    assign r_stall = (r_st == CH_RESP) && !s_axi_rready;

    assign s_axi_awready = up_q && !aw_hold && !b_stall;
    assign s_axi_wready  = up_q && !w_hold && !b_stall;
    assign s_axi_arready = up_q && !r_stall;
    assign s_axi_bvalid  = (b_st == CH_RESP);
    assign s_axi_rvalid  = (r_st == CH_RESP);

    assign aw_acc = s_axi_awvalid && s_axi_awready;
    assign w_acc  = s_axi_wvalid && s_axi_wready;

    // Commit once both halves are held and B can take a response
    assign wr_en   = aw_hold && w_hold && !b_stall;
    assign wr_addr = aw_q;
    assign wr_data = w_q;
    assign wr_strb = ws_q;

    assign rd_en       = s_axi_arvalid && s_axi_arready;
    assign rd_addr     = s_axi_araddr;
    assign rd_ack      = (r_st == CH_RESP) && s_axi_rready;
    assign rd_ack_addr = ar_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            up_q        <= 1'b0;
            aw_hold     <= 1'b0;
            w_hold      <= 1'b0;
            aw_q        <= '0;
            w_q         <= '0;
            ws_q        <= '0;
            ar_q        <= '0;
            b_st        <= CH_IDLE;
            r_st        <= CH_IDLE;
            s_axi_bresp <= RESP_OKAY;
            s_axi_rresp <= RESP_OKAY;
            s_axi_rdata <= '0;
        end else begin
            up_q <= 1'b1;
            if (aw_acc) begin
                aw_hold <= 1'b1;
                aw_q    <= s_axi_awaddr;
            end else if (wr_en) begin
                aw_hold <= 1'b0;
            end
            if (w_acc) begin
                w_hold <= 1'b1;
                w_q    <= s_axi_wdata;
                ws_q   <= s_axi_wstrb;
            end else if (wr_en) begin
                w_hold <= 1'b0;
            end
            if (wr_en) begin
                b_st        <= CH_RESP;
                s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bready) begin
                b_st <= CH_IDLE;
            end
            if (rd_en) begin
                r_st        <= CH_RESP;
                ar_q        <= s_axi_araddr;
                s_axi_rdata <= rd_data;
                s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_rready) begin
                r_st <= CH_IDLE;
            end
        end
    end

endmodule

// File: rtl/dtpu_csr_slave.sv
// DTPU CSR bank: AXI4-Lite registers, start/ready/done
// handshake and the control unit's read-only CSR port.
module dtpu_csr_slave
    import dtpu_csr_slave_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int DATA_WIDTH_CSR     = 8,
    parameter int ADDRESS_SIZE_CSR   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic                            csr_ce,
    input  logic                            csr_we,
    input  logic [ADDRESS_SIZE_CSR-1:0]     csr_address,
    input  logic                            csr_reset,
    output logic [DATA_WIDTH_CSR-1:0]       csr_dout,
    output logic                            cs_start,
    output logic                            cs_continue,
    output logic                            glb_enable,
    input  logic                            cs_ready,
    input  logic                            cs_done,
    input  logic                            cs_idle,
    input  logic [3:0]                      cu_state
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_strb;
    logic            wr_err;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_err;
    logic            rd_ack;
    logic [AW-1:0]   rd_ack_addr;

    logic [3:0]  wr_word;
    logic [3:0]  rd_word;
    logic        wr_b0;
    logic        wr_ctrl;
    logic        wr_prec;
    logic        wr_wm;
    logic        ack_ctrl;
    logic        clr_done;
    logic        clr_ready;
    logic        ce_prec;
    logic        ce_wm;

    logic        start_q;
    logic        done_q;
    logic        ready_q;
    logic        glb_q;
    logic        cont_q;
    logic [7:0]  prec_q;
    logic [7:0]  wm_q;
    logic [31:0] done_cnt;

    logic        unused_bits;

    dtpu_csr_slave_axil_slave_if #(
        .AW (AW),
        .DW (DW)
    ) u_axil (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_err        (wr_err),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .rd_ack        (rd_ack),
        .rd_ack_addr   (rd_ack_addr)
    );

    assign wr_word = wr_addr[5:2];
    assign rd_word = rd_addr[5:2];
    assign wr_err  = !is_mapped(wr_word);
    assign rd_err  = !is_mapped(rd_word);

    assign wr_b0   = wr_en && wr_strb[0];
    assign wr_ctrl = wr_b0 && (wr_word == W_CTRL);
    assign wr_prec = wr_b0 && (wr_word == W_PREC);
    assign wr_wm   = wr_b0 && (wr_word == W_WM);

    // Only clear what the returned beat actually reported
    assign ack_ctrl  = rd_ack && (rd_ack_addr[5:2] == W_CTRL);
    assign clr_done  = ack_ctrl && s_axi_rdata[B_DONE];
    assign clr_ready = ack_ctrl && s_axi_rdata[B_READY];

    assign ce_prec = csr_ce && !csr_reset &&
        (csr_address == ADDRESS_SIZE_CSR'(A_ARITHMETIC_PRECISION));
    assign ce_wm   = csr_ce && !csr_reset &&
        (csr_address == ADDRESS_SIZE_CSR'(A_FP_MODE));

    assign cs_start    = start_q;
    assign cs_continue = cont_q;
    assign glb_enable  = glb_q;

    always_comb begin
        rd_data = '0;
        unique case (rd_word)
            W_CTRL: begin
                rd_data[B_START] = start_q;
                rd_data[B_DONE]  = done_q;
                rd_data[B_IDLE]  = cs_idle;
                rd_data[B_READY] = ready_q;
                rd_data[B_GLB]   = glb_q;
            end
            W_PREC:  rd_data[7:0] = prec_q;
            W_WM:    rd_data[7:0] = wm_q;
            W_STAT:  rd_data[3:0] = cu_state;
            W_DCNT:  rd_data = DW'(done_cnt);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            glb_q    <= 1'b0;
            cont_q   <= 1'b0;
            prec_q   <= '0;
            wm_q     <= '0;
            done_cnt <= '0;
            csr_dout <= '0;
        end else begin
            start_q <= (start_q && !cs_ready) ||
                       (wr_ctrl && wr_data[B_START]);
            if (wr_ctrl) glb_q <= wr_data[B_GLB];
            cont_q   <= wr_ctrl && wr_data[B_CONT];
            done_q   <= cs_done || (done_q && !clr_done);
            ready_q  <= cs_ready || (ready_q && !clr_ready);
            done_cnt <= done_cnt + 32'(cs_done);
            if (csr_reset) begin
                prec_q <= '0;
                wm_q   <= '0;
            end else begin
                if (wr_prec) prec_q <= wr_data[7:0];
                if (wr_wm)   wm_q   <= wr_data[7:0];
            end
            unique case (1'b1)
                csr_reset: csr_dout <= '0;
                ce_prec:   csr_dout <= DATA_WIDTH_CSR'(prec_q);
                ce_wm:     csr_dout <= DATA_WIDTH_CSR'(wm_q);
                default:   ;
            endcase
        end
    end

    assign unused_bits = &{1'b0, csr_we, rd_en,
                           wr_addr[1:0], rd_addr[1:0],
                           rd_ack_addr[1:0], wr_data[DW-1:8],
                           wr_strb[DW/8-1:1]};

endmodule

// File: tb/tb_dtpu_csr_slave.sv
// Directed bench for dtpu_csr_slave: AXI map, handshake,
// CU CSR port, response ordering and reset behaviour.
module tb_dtpu_csr_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        csr_ce;
    logic        csr_we;
    logic [31:0] csr_address;
    logic        csr_reset;
    logic [7:0]  csr_dout;
    logic        cs_start;
    logic        cs_continue;
    logic        glb_enable;
    logic        cs_ready;
    logic        cs_done;
    logic        cs_idle;
    logic [3:0]  cu_state;

    int n_vec = 0;
    int n_err = 0;
    int cont_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (cs_continue) cont_cnt++;

    dtpu_csr_slave dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .csr_ce        (csr_ce),
        .csr_we        (csr_we),
        .csr_address   (csr_address),
        .csr_reset     (csr_reset),
        .csr_dout      (csr_dout),
        .cs_start      (cs_start),
        .cs_continue   (cs_continue),
        .glb_enable    (glb_enable),
        .cs_ready      (cs_ready),
        .cs_done       (cs_done),
        .cs_idle       (cs_idle),
        .cu_state      (cu_state)
    );

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        logic aa;
        logic wa;
        n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            #4;
            aa = awvalid && awready;
            wa = wvalid && wready;
            @(posedge clk); #1;
            if (aa) awvalid = 1'b0;
            if (wa) wvalid = 1'b0;
            n++;
        end
        while (!bvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        resp = bresp;
        n_vec++;
        if (bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL wr_timeout addr=%h bvalid=%b want 1", a, bvalid);
        end
        @(posedge clk); #1;
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        logic ra;
        n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (arvalid && n < 20) begin
            #4;
            ra = arvalid && arready;
            @(posedge clk); #1;
            if (ra) arvalid = 1'b0;
            n++;
        end
        while (!rvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        d = rdata;
        resp = rresp;
        n_vec++;
        if (rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rd_timeout addr=%h rvalid=%b want 1", a, rvalid);
        end
        @(posedge clk); #1;
        rready = 1'b0; arvalid = 1'b0;
    endtask

    task automatic cu_access(input logic ce, input logic [31:0] idx);
        @(negedge clk);
        csr_ce = ce; csr_address = idx;
        @(posedge clk); #1;
        csr_ce = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (awready !== 1'b0) begin
            n_err++; $display("FAIL awready_in_reset got %b want 0", awready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_err++; $display("FAIL ready_after_reset got %b want 111", {awready, wready, arready});
        end
        n_vec++;
        if ({bvalid, rvalid, cs_start, cs_continue, glb_enable} !== 5'b0) begin
            n_err++; $display("FAIL outs_after_reset got %b want 00000",
                {bvalid, rvalid, cs_start, cs_continue, glb_enable});
        end
        n_vec++;
        if (csr_dout !== 8'h00) begin
            n_err++; $display("FAIL dout_reset got %h want 00", csr_dout);
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h0 || r !== 2'b00) begin
            n_err++; $display("FAIL ctrl_reset got %h/%b want 0/00", d, r);
        end
        axi_read(6'h1C, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL dcnt_reset got %h want 0", d);
        end
    endtask

    task automatic test_cu_port();
        logic [31:0] d;
        logic [1:0] r;
        axi_write(6'h10, 32'h0A, 4'hF, r);
        n_vec++;
        if (r !== 2'b00) begin
            n_err++; $display("FAIL prec_wr_resp got %b want 00", r);
        end
        cu_access(1'b1, 32'd1);
        n_vec++;
        if (csr_dout !== 8'h0A) begin
            n_err++; $display("FAIL cu_prec got %h want 0a", csr_dout);
        end
        cu_access(1'b1, 32'd0);
        n_vec++;
        if (csr_dout !== 8'h0A) begin
            n_err++; $display("FAIL cu_idx0_hold got %h want 0a", csr_dout);
        end
        axi_write(6'h14, 32'h5C, 4'hF, r);
        cu_access(1'b1, 32'd2);
        n_vec++;
        if (csr_dout !== 8'h5C) begin
            n_err++; $display("FAIL cu_wm got %h want 5c", csr_dout);
        end
        cu_access(1'b0, 32'd1);
        n_vec++;
        if (csr_dout !== 8'h5C) begin
            n_err++; $display("FAIL cu_ce0_hold got %h want 5c", csr_dout);
        end
        axi_write(6'h10, 32'hFF, 4'hE, r);
        axi_read(6'h10, d, r);
        n_vec++;
        if (d !== 32'h0A) begin
            n_err++; $display("FAIL strb_gate got %h want 0a", d);
        end
        @(negedge clk);
        csr_reset = 1'b1;
        @(posedge clk); #1;
        csr_reset = 1'b0;
        n_vec++;
        if (csr_dout !== 8'h00) begin
            n_err++; $display("FAIL csr_reset_dout got %h want 00", csr_dout);
        end
        axi_read(6'h10, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL csr_reset_prec got %h want 0", d);
        end
        axi_read(6'h14, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL csr_reset_wm got %h want 0", d);
        end
    endtask

    task automatic pulse_ready(input logic [31:0] tag);
        @(negedge clk);
        cs_ready = 1'b1;
        #4;
        n_vec++;
        if (cs_start !== 1'b1) begin
            n_err++; $display("FAIL start_during_ready%0d got %b want 1", tag, cs_start);
        end
        @(posedge clk); #1;
        cs_ready = 1'b0;
        n_vec++;
        if (cs_start !== 1'b0) begin
            n_err++; $display("FAIL start_after_ready%0d got %b want 0", tag, cs_start);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        logic [1:0] r;
        int c0;
        cs_idle = 1'b1;
        axi_write(6'h00, 32'h11, 4'hF, r);
        n_vec++;
        if ({cs_start, glb_enable} !== 2'b11) begin
            n_err++; $display("FAIL start_glb got %b want 11", {cs_start, glb_enable});
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h15) begin
            n_err++; $display("FAIL ctrl_started got %h want 15", d);
        end
        pulse_ready(1);
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h1C) begin
            n_err++; $display("FAIL ready_sticky got %h want 1c", d);
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h14) begin
            n_err++; $display("FAIL ready_cleared got %h want 14", d);
        end
        c0 = cont_cnt;
        axi_write(6'h00, 32'h30, 4'hF, r);
        n_vec++;
        if (cont_cnt !== c0 + 1 || cs_continue !== 1'b0) begin
            n_err++; $display("FAIL continue_pulse got %0d/%b want %0d/0",
                cont_cnt - c0, cs_continue, 1);
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h14) begin
            n_err++; $display("FAIL continue_reads0 got %h want 14", d);
        end
        axi_write(6'h00, 32'h01, 4'hF, r);
        n_vec++;
        if ({cs_start, glb_enable} !== 2'b10) begin
            n_err++; $display("FAIL start_noglb got %b want 10", {cs_start, glb_enable});
        end
        axi_write(6'h00, 32'h00, 4'hF, r);
        n_vec++;
        if (cs_start !== 1'b1) begin
            n_err++; $display("FAIL start_w0 got %b want 1", cs_start);
        end
        pulse_ready(2);
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h0C) begin
            n_err++; $display("FAIL ready2 got %h want 0c", d);
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h04) begin
            n_err++; $display("FAIL ready2_clr got %h want 04", d);
        end
        cs_idle = 1'b0;
    endtask

    task automatic test_done();
        logic [31:0] d;
        logic [1:0] r;
        @(negedge clk);
        araddr = 6'h00; arvalid = 1'b1; rready = 1'b1; cs_done = 1'b1;
        #4;
        n_vec++;
        if (arready !== 1'b1) begin
            n_err++; $display("FAIL done_arready got %b want 1", arready);
        end
        @(posedge clk); #1;
        arvalid = 1'b0; cs_done = 1'b0;
        n_vec++;
        if (rvalid !== 1'b1 || rdata !== 32'h0) begin
            n_err++; $display("FAIL done_race_rd got %b/%h want 1/0", rvalid, rdata);
        end
        @(posedge clk); #1;
        rready = 1'b0;
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h02) begin
            n_err++; $display("FAIL done_set got %h want 02", d);
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h00) begin
            n_err++; $display("FAIL done_clr got %h want 00", d);
        end
        axi_read(6'h1C, d, r);
        n_vec++;
        if (d !== 32'h1) begin
            n_err++; $display("FAIL done_count got %h want 1", d);
        end
    endtask

    task automatic test_aw_early();
        logic [31:0] d;
        logic [1:0] r;
        @(negedge clk);
        awaddr = 6'h14; awvalid = 1'b1; bready = 1'b0;
        #4;
        n_vec++;
        if (awready !== 1'b1) begin
            n_err++; $display("FAIL aw_first got %b want 1", awready);
        end
        @(posedge clk); #1;
        awaddr = 6'h10;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_vec++;
            if (awready !== 1'b0) begin
                n_err++; $display("FAIL aw_held%0d got %b want 0", i, awready);
            end
            @(posedge clk); #1;
        end
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        #4;
        n_vec++;
        if (wready !== 1'b1) begin
            n_err++; $display("FAIL w_late got %b want 1", wready);
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (awready !== 1'b0) begin
                n_err++; $display("FAIL aw_bstall%0d got %b want 0", i, awready);
            end
        end
        n_vec++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_err++; $display("FAIL b_held got %b/%b want 1/00", bvalid, bresp);
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_vec++;
        if (bvalid !== 1'b0) begin
            n_err++; $display("FAIL b_single got %b want 0", bvalid);
        end
        axi_read(6'h14, d, r);
        n_vec++;
        if (d !== 32'h77) begin
            n_err++; $display("FAIL late_w_data got %h want 77", d);
        end
        axi_read(6'h10, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL second_aw_dropped got %h want 0", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0] r;
        axi_read(6'h24, d, r);
        n_vec++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_err++; $display("FAIL unmapped_rd got %h/%b want 0/10", d, r);
        end
        axi_write(6'h24, 32'hFFFF_FFFF, 4'hF, r);
        n_vec++;
        if (r !== 2'b10) begin
            n_err++; $display("FAIL unmapped_wr got %b want 10", r);
        end
        axi_read(6'h14, d, r);
        n_vec++;
        if (d !== 32'h77) begin
            n_err++; $display("FAIL unmapped_wm got %h want 77", d);
        end
        axi_read(6'h00, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL unmapped_ctrl got %h want 0", d);
        end
        axi_read(6'h18, d, r);
        n_vec++;
        if (d !== 32'h9 || r !== 2'b00) begin
            n_err++; $display("FAIL status got %h/%b want 9/00", d, r);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [1:0] r;
        @(negedge clk);
        force dut.done_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.done_cnt;
        axi_read(6'h1C, d, r);
        n_vec++;
        if (d !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL dcnt_preload got %h want ffffffff", d);
        end
        @(negedge clk);
        cs_done = 1'b1;
        @(negedge clk);
        cs_done = 1'b0;
        axi_read(6'h1C, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL dcnt_wrap got %h want 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0] r;
        @(negedge clk);
        awaddr = 6'h10; wdata = 32'h33; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 6'h14; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_vec++;
        if (rvalid !== 1'b1) begin
            n_err++; $display("FAIL mid_rvalid got %b want 1", rvalid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bvalid, rvalid} !== 2'b00) begin
                n_err++; $display("FAIL mid_dropped%0d got %b want 00", i, {bvalid, rvalid});
            end
        end
        axi_read(6'h10, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL mid_prec got %h want 0", d);
        end
        axi_read(6'h1C, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL mid_dcnt got %h want 0", d);
        end
    endtask

    initial begin
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        csr_ce = 1'b0; csr_we = 1'b0; csr_address = '0;
        csr_reset = 1'b0;
        cs_ready = 1'b0; cs_done = 1'b0; cs_idle = 1'b0;
        cu_state = 4'h9;
        test_reset();
        test_cu_port();
        test_handshake();
        test_done();
        test_aw_early();
        test_unmapped();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
